// File: rtl/uart_pkg.sv
// uart_pkg: frame FSM encoding and default sizing shared by the UART receiver and transmitter
package uart_pkg;
   typedef enum logic [1:0] {S_Idle, S_Start, S_Data, S_Stop} uart_state_t;
   localparam int DWL_DEFAULT        = 8;
   localparam int OVERSAMPLE_DEFAULT = 16;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous input, resets to 1 (idle line level)
module uart_sync2 (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);
   logic [1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[0], d};
   always_ff @(posedge CLK) sync_q <= RST ? 2'b11 : sync_d;
   assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (8N1-style, DWL data bits LSB first) with valid/ack handoff and error flags
module uart_rx
   import uart_pkg::*;
#(
   parameter int DWL        = DWL_DEFAULT,
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           EN,
   input  logic           serialData,
   input  logic           RE,
   output logic [DWL-1:0] parallelData,
   output logic           VALID,
   output logic           FERR,
   output logic           OERR,
   output logic           BUSY
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DWL);
   localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DWL - 1);

   logic           rx_s;
   uart_state_t    state_q, state_d;
   logic           armed_q, armed_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [BW-1:0]  bit_idx_q, bit_idx_d;
   logic [DWL-1:0] shreg_q, shreg_d;
   logic [DWL-1:0] data_q, data_d;
   logic           valid_q, valid_d;
   logic           ferr_q, ferr_d;
   logic           oerr_q, oerr_d;

   uart_sync2 u_sync (.CLK(CLK), .RST(RST), .d(serialData), .q(rx_s));

   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      tick_d    = tick_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = RE ? 1'b0 : valid_q;
      oerr_d    = RE ? 1'b0 : oerr_q;
      ferr_d    = 1'b0;
      if (EN) begin
         if (rx_s) armed_d = 1'b1;
         case (state_q)
            S_Idle:
               if (armed_q && !rx_s) begin
                  state_d = S_Start;
                  tick_d  = '0;
                  armed_d = 1'b0;
               end
            S_Start:
               if (tick_q == T_HALF) begin
                  state_d   = rx_s ? S_Idle : S_Data;
                  tick_d    = '0;
                  bit_idx_d = '0;
               end else tick_d = tick_q + TW'(1);
            S_Data:
               if (tick_q == T_LAST) begin
                  shreg_d   = {rx_s, shreg_q[DWL-1:1]};
                  tick_d    = '0;
                  state_d   = (bit_idx_q == B_LAST) ? S_Stop : S_Data;
                  bit_idx_d = (bit_idx_q == B_LAST) ? bit_idx_q : bit_idx_q + BW'(1);
               end else tick_d = tick_q + TW'(1);
            S_Stop:
               if (tick_q == T_LAST) begin
                  state_d = S_Idle;
                  if (rx_s) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                     if (valid_q && !RE) oerr_d = 1'b1;
                  end else begin
                     ferr_d  = 1'b1;
                     // a line still low after a bad stop is a break; wait for it to go high before rearming
                     armed_d = 1'b0;
                  end
               end else tick_d = tick_q + TW'(1);
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_Idle;
         armed_q   <= 1'b0;
         tick_q    <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         oerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         armed_q   <= armed_d;
         tick_q    <= tick_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         oerr_q    <= oerr_d;
      end
   end

   assign parallelData = data_q;
   assign VALID        = valid_q;
   assign FERR         = ferr_q;
   assign OERR         = oerr_q;
   assign BUSY         = state_q != S_Idle;
endmodule
